// File: rtl/dptr_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset datapath: opcodes, functs,
// FSM states, ALU operations and the legal-instruction decoder.
package dptr_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OP_RTYPE: return (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT});
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/banco_reg.sv
// Register file: NREG x DATA_W, two asynchronous read ports, one synchronous
// write port. Register 0 always reads zero and ignores writes.
module banco_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [AW-1:0]     i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata
);

  logic [DATA_W-1:0] r_regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/dptr_multiciclo.sv
// Multi-cycle MIPS-subset datapath with FSM control, req/ack instruction and
// data memory interfaces, halt state and illegal-opcode flagging.
module dptr_multiciclo
  import dptr_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       NREG     = 32,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] pc_out,
  output logic              zf,
  output logic              halted,
  output logic              illegal
);

  localparam int unsigned AW = $clog2(NREG);

  state_t            r_state;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_pc, r_a, r_b, r_aluout, r_mdr;
  logic              r_zf, r_imem_req, r_dmem_req, r_dmem_we, r_halted, r_illegal;

  logic [5:0]        w_op, w_fn;
  logic [AW-1:0]     w_rs, w_rt, w_rd, w_waddr;
  logic [DATA_W-1:0] w_imm_sext, w_br_off, w_rd_a, w_rd_b;
  logic [DATA_W-1:0] w_alu_b, w_alu_res, w_wdata;
  logic              w_we, w_unused;
  alu_op_t           w_alu_op;

  assign w_op       = r_ir[31:26];
  assign w_fn       = r_ir[5:0];
  assign w_rs       = r_ir[21 +: AW];
  assign w_rt       = r_ir[16 +: AW];
  assign w_rd       = r_ir[11 +: AW];
  assign w_imm_sext = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
  assign w_br_off   = {{(DATA_W-18){r_ir[15]}}, r_ir[15:0], 2'b00};
  assign w_unused   = ^r_ir[10:6];

  always_comb begin
    w_alu_op = ALU_ADD;
    w_alu_b  = w_imm_sext;
    if (w_op == OP_RTYPE) begin
      w_alu_b = r_b;
      case (w_fn)
        FN_SUB:  w_alu_op = ALU_SUB;
        FN_AND:  w_alu_op = ALU_AND;
        FN_OR:   w_alu_op = ALU_OR;
        FN_SLT:  w_alu_op = ALU_SLT;
        default: w_alu_op = ALU_ADD;
      endcase
    end
  end

  always_comb begin
    w_alu_res = '0;
    case (w_alu_op)
      ALU_ADD: w_alu_res = r_a + w_alu_b;
      ALU_SUB: w_alu_res = r_a - w_alu_b;
      ALU_AND: w_alu_res = r_a & w_alu_b;
      ALU_OR:  w_alu_res = r_a | w_alu_b;
      ALU_SLT: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(w_alu_b))};
      default: w_alu_res = '0;
    endcase
  end

  assign w_we    = (r_state == S_WB);
  assign w_waddr = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_wdata = (w_op == OP_LW) ? r_mdr : r_aluout;

  banco_reg #(
    .DATA_W (DATA_W),
    .NREG   (NREG),
    .AW     (AW)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rd_a),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_rd_b),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_pc       <= PC_RESET;
      r_ir       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_aluout   <= '0;
      r_mdr      <= '0;
      r_zf       <= 1'b0;
      r_imem_req <= 1'b1;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir       <= imem_rdata;
            r_pc       <= r_pc + DATA_W'(4);
            r_imem_req <= 1'b0;
            // Decoded from the incoming word so the registered pulse lands in DECODE.
            r_illegal  <= !is_legal(imem_rdata[31:26], imem_rdata[5:0]);
            r_state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a      <= w_rd_a;
          r_b      <= w_rd_b;
          r_aluout <= r_pc + w_br_off;
          if (w_op == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (!is_legal(w_op, w_fn)) begin
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_op == OP_BEQ) begin
            r_zf <= (r_a == r_b);
            if (r_a == r_b) r_pc <= r_aluout;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_aluout <= w_alu_res;
            r_zf     <= (w_alu_res == '0);
            if ((w_op == OP_LW) || (w_op == OP_SW)) begin
              r_dmem_req <= 1'b1;
              r_dmem_we  <= (w_op == OP_SW);
              r_state    <= S_MEM;
            end else begin
              r_state <= S_WB;
            end
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (w_op == OP_LW) begin
              r_mdr   <= dmem_rdata;
              r_state <= S_WB;
            end else begin
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        S_WB: begin
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_pc;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_aluout;
  assign dmem_wdata = r_b;
  assign pc_out     = r_pc;
  assign zf         = r_zf;
  assign halted     = r_halted;
  assign illegal    = r_illegal;

endmodule
